seq_packer: RTL and testbench
=============================

SEQ_PACKER -- requirements
Module: seq_packer

Interface
REQ-001 Parameter IN_W, default 7, max valid bits per input beat; SHALL satisfy 1 <= IN_W <= OUT_W.
REQ-002 Parameter OUT_W, default 16, bits per output word.
REQ-003 Derived CNT_W = $clog2(IN_W+1), in_num width; FILL_W = $clog2(OUT_W+IN_W), fill-counter width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 in_seq  input  IN_W  data; bits in_seq[in_num-1:0] valid, in_seq[in_num-1] oldest.
REQ-009 in_num  input  CNT_W  count of valid bits, 0..IN_W.
REQ-010 out_valid  output  1  out_seq holds a complete word.
REQ-011 out_ready  input  1  downstream accepts word.
REQ-012 out_seq  output  OUT_W  packed word, out_seq[OUT_W-1] = oldest bit.
REQ-013 fill  output  FILL_W  count of bits currently held.

Function
REQ-014 Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-015 Bit order SHALL be preserved end to end: first bit received is first emitted, MSB-first in each word.
REQ-016 Storage capacity SHALL be OUT_W+IN_W-1 bits; no bit SHALL ever be dropped or duplicated.
REQ-017 out_valid SHALL equal (fill >= OUT_W), driven from registers only.
REQ-018 out_seq SHALL be the oldest OUT_W held bits, register-driven, stable while out_valid & ~out_ready.
REQ-019 in_ready SHALL equal (fill < OUT_W) | out_ready (combinational path out_ready->in_ready permitted and documented).
REQ-020 Next fill = fill + (input fire ? in_num : 0) - (output fire ? OUT_W : 0); simultaneous fires SHALL both take effect in the same cycle.
REQ-021 Latency: a beat completing a word SHALL raise out_valid on the next cycle.
REQ-022 Input fire with in_num = 0 SHALL be a no-op (no state change).
REQ-023 in_num > IN_W SHALL be clamped to IN_W.
REQ-024 Leftover bits after an output fire SHALL remain, oldest first, and prefix the next word.

Reset
REQ-025 While rst is high at a clock edge: fill = 0, storage = 0, out_valid = 0, out_seq = 0, in_ready = 0 during reset cycle.
REQ-026 Reset mid-word SHALL discard all held bits; first post-reset bit SHALL be MSB of the next word.
REQ-027 in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-028 Macro SEQ_PACKER_FLUSH_EN defined: adds ports flush (input, 1) and out_last (output, 1).
REQ-029 With SEQ_PACKER_FLUSH_EN: flush high sets a pending flag; while pending, in_ready = 0; once fill < OUT_W and fill > 0, block SHALL present held bits MSB-aligned, zero-padded, with out_valid = out_last = 1; on output fire fill = 0, pending clears; if fill = 0, pending clears with no output.
REQ-030 With SEQ_PACKER_FLUSH_EN: out_last = 0 for every full word; reset clears pending and out_last.
REQ-031 Without SEQ_PACKER_FLUSH_EN: no flush/out_last ports; partial bits remain held until completed by later input.

Verification
REQ-032 Defaults, out_ready=1; beats (7,1111111),(7,1000011),(3,xxxx110) -> one word 16'b1111111100001111, fill=1 after.
REQ-033 out_ready=0 with fill=16, in_valid=1 in_num=7 -> in_ready=0, out_seq stable, fill stays 16 over 10 cycles.
REQ-034 fill=20, out_ready=1, input (7) same cycle -> fill=11, 4 leftover bits are MSBs of next word.
REQ-035 rst asserted at fill=9 -> next cycle fill=0, out_valid=0; 16 fresh bits -> word contains no pre-reset bits.
REQ-036 FLUSH_EN, fill=5 bits 10110, flush pulse -> out_seq=16'b1011000000000000, out_last=1, then fill=0.
REQ-037 IN_W=3, OUT_W=8, random in_num/valid/ready 10k cycles -> output bitstream equals input bitstream (scoreboard).

Source files
------------

// File: rtl/seq_packer_if.sv
// rtl/seq_packer_if.sv - input-beat / output-word handshake bundle for seq_packer.
// Optional flush/out_last signals exist only when SEQ_PACKER_FLUSH_EN is defined.
interface seq_packer_if #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 16
);
    localparam int CNT_W  = $clog2(IN_W + 1);
    localparam int FILL_W = $clog2(OUT_W + IN_W);

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_seq;
    logic [CNT_W-1:0]  in_num;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_seq;
    logic [FILL_W-1:0] fill;

`ifdef SEQ_PACKER_FLUSH_EN
    logic              flush;
    logic              out_last;

    modport master (
        output in_valid, in_seq, in_num, out_ready, flush,
        input  in_ready, out_valid, out_seq, fill, out_last
    );
    modport slave (
        input  in_valid, in_seq, in_num, out_ready, flush,
        output in_ready, out_valid, out_seq, fill, out_last
    );
`else
    modport master (
        output in_valid, in_seq, in_num, out_ready,
        input  in_ready, out_valid, out_seq, fill
    );
    modport slave (
        input  in_valid, in_seq, in_num, out_ready,
        output in_ready, out_valid, out_seq, fill
    );
`endif
endinterface

// File: rtl/seq_packer.sv
// rtl/seq_packer.sv - packs variable-length bit beats into OUT_W-bit words, oldest bit first.
// Define SEQ_PACKER_FLUSH_EN to add flush/out_last for emitting a zero-padded final word.
module seq_packer #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    seq_packer_if.slave bus
);
    localparam int CNT_W  = $clog2(IN_W + 1);
    localparam int FILL_W = $clog2(OUT_W + IN_W);
    localparam int CAP    = OUT_W + IN_W - 1;

    // Held bits are left-aligned: oldest at r_buf[CAP-1], everything below fill is zero.
    logic [CAP-1:0]    r_buf;
    logic [FILL_W-1:0] r_fill;
    logic              r_out_valid;

    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [CNT_W-1:0]  w_num;
    logic [IN_W-1:0]   w_in_bits;
    logic [CAP-1:0]    w_buf_n;
    logic [FILL_W-1:0] w_fill_n;
    logic              w_word_n;
    int                v_base;
    int                v_fill;

`ifdef SEQ_PACKER_FLUSH_EN
    logic              r_pend;
    logic              r_out_last;
    logic              w_pend_n;
    logic              w_last_n;
    logic              w_last_fire;

    assign w_last_fire = w_out_fire & r_out_last;
    assign w_pend_n    = bus.flush | (r_pend & ~w_last_fire & (r_fill != '0));
    assign w_last_n    = w_pend_n & (w_fill_n != '0) & (w_fill_n < FILL_W'(OUT_W));
    assign bus.out_last = r_out_last;
    // out_ready feeds in_ready combinationally so a full word can drain and refill in one cycle.
    assign w_in_ready  = ~rst & ~r_pend & ((r_fill < FILL_W'(OUT_W)) | bus.out_ready);
`else
    assign w_in_ready  = ~rst & ((r_fill < FILL_W'(OUT_W)) | bus.out_ready);
`endif

    assign w_num      = (bus.in_num > CNT_W'(IN_W)) ? CNT_W'(IN_W) : bus.in_num;
    assign w_out_fire = r_out_valid & bus.out_ready;
    assign w_in_fire  = bus.in_valid & w_in_ready & (w_num != '0);
    assign w_word_n   = (w_fill_n >= FILL_W'(OUT_W));

    always_comb begin
        w_in_bits = '0;
        for (int i = 0; i < IN_W; i++) begin
            w_in_bits[i] = bus.in_seq[i] & (i < int'(w_num));
        end
    end

    always_comb begin
        w_buf_n = r_buf;
        v_base  = int'(r_fill);
`ifdef SEQ_PACKER_FLUSH_EN
        if (w_last_fire) begin
            w_buf_n = '0;
            v_base  = 0;
        end else if (w_out_fire) begin
            w_buf_n = r_buf << OUT_W;
            v_base  = int'(r_fill) - OUT_W;
        end
`else
        if (w_out_fire) begin
            w_buf_n = r_buf << OUT_W;
            v_base  = int'(r_fill) - OUT_W;
        end
`endif
        v_fill = v_base;
        // New bits land directly behind the surviving ones, newest toward the LSB end.
        if (w_in_fire) begin
            w_buf_n = w_buf_n | (CAP'(w_in_bits) << (CAP - v_base - int'(w_num)));
            v_fill  = v_base + int'(w_num);
        end
        w_fill_n = FILL_W'(v_fill);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf       <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
`ifdef SEQ_PACKER_FLUSH_EN
            r_pend      <= 1'b0;
            r_out_last  <= 1'b0;
`endif
        end else begin
            r_buf       <= w_buf_n;
            r_fill      <= w_fill_n;
`ifdef SEQ_PACKER_FLUSH_EN
            r_pend      <= w_pend_n;
            r_out_last  <= w_last_n;
            r_out_valid <= w_word_n | w_last_n;
`else
            r_out_valid <= w_word_n;
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_seq   = r_buf[CAP-1 -: OUT_W];
    assign bus.fill      = r_fill;
endmodule

// File: tb/tb_seq_packer.sv
// tb/tb_seq_packer.sv - bench for seq_packer: bit-list model plus directed literal checks.
module tb_seq_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_valid [2] = '{1'b0, 1'b0};
    logic        d_ordy  [2] = '{1'b0, 1'b0};
    logic [31:0] d_seq   [2] = '{32'd0, 32'd0};
    int          d_num   [2] = '{0, 0};
    logic        flush0 = 1'b0;

    logic        a_ir   [2];
    logic        a_ov   [2];
    logic [31:0] a_seq  [2];
    logic [31:0] a_fill [2];

    bit          mbuf [2][64];
    int          mcnt [2] = '{0, 0};
    bit          chk_en [2] = '{1'b1, 1'b1};
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    seq_packer_if #(.IN_W(7), .OUT_W(16)) ifa ();
    seq_packer_if #(.IN_W(3), .OUT_W(8))  ifb ();

    seq_packer #(.IN_W(7), .OUT_W(16)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    seq_packer #(.IN_W(3), .OUT_W(8))  u_b (.clk(clk), .rst(rst), .bus(ifb));

    assign ifa.in_valid  = d_valid[0];
    assign ifa.in_seq    = d_seq[0][6:0];
    assign ifa.in_num    = 3'(d_num[0]);
    assign ifa.out_ready = d_ordy[0];
    assign ifb.in_valid  = d_valid[1];
    assign ifb.in_seq    = d_seq[1][2:0];
    assign ifb.in_num    = 2'(d_num[1]);
    assign ifb.out_ready = d_ordy[1];
`ifdef SEQ_PACKER_FLUSH_EN
    assign ifa.flush = flush0;
    assign ifb.flush = 1'b0;
`endif

    assign a_ir[0]   = ifa.in_ready;
    assign a_ov[0]   = ifa.out_valid;
    assign a_seq[0]  = 32'(ifa.out_seq);
    assign a_fill[0] = 32'(ifa.fill);
    assign a_ir[1]   = ifb.in_ready;
    assign a_ov[1]   = ifb.out_valid;
    assign a_seq[1]  = 32'(ifb.out_seq);
    assign a_fill[1] = 32'(ifb.fill);

    function automatic int iw_of(input int k);
        return (k == 0) ? 7 : 3;
    endfunction

    function automatic int ow_of(input int k);
        return (k == 0) ? 16 : 8;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: an ordered list of held bits; words are its first OW entries.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mcnt[k] = 0;
            end else begin
                int  ow;
                int  n;
                bit  ir;
                ow = ow_of(k);
                ir = (mcnt[k] < ow) || d_ordy[k];
                if (mcnt[k] >= ow && d_ordy[k]) begin
                    for (int i = 0; i < mcnt[k] - ow; i++) mbuf[k][i] = mbuf[k][i + ow];
                    mcnt[k] = mcnt[k] - ow;
                end
                if (d_valid[k] && ir) begin
                    n = (d_num[k] > iw_of(k)) ? iw_of(k) : d_num[k];
                    for (int i = n - 1; i >= 0; i--) begin
                        mbuf[k][mcnt[k]] = d_seq[k][i];
                        mcnt[k]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (chk_en[k]) begin
                logic [31:0] w;
                bit          ev;
                ev = (mcnt[k] >= ow_of(k));
                w  = 32'd0;
                for (int i = 0; i < ow_of(k); i++) w = (w << 1) | 32'(mbuf[k][i]);
                chk($sformatf("in_ready%0d", k), 32'(a_ir[k]),
                    32'(!rst && ((mcnt[k] < ow_of(k)) || d_ordy[k])));
                chk($sformatf("out_valid%0d", k), 32'(a_ov[k]), 32'(ev));
                chk($sformatf("fill%0d", k), a_fill[k], 32'(mcnt[k]));
                if (ev) chk($sformatf("out_seq%0d", k), a_seq[k], w);
`ifdef SEQ_PACKER_FLUSH_EN
                if (ev && k == 0) chk("out_last_full", 32'(ifa.out_last), 32'd0);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic beat(input int n, input logic [31:0] v);
        d_valid[0] = 1'b1;
        d_num[0]   = n;
        d_seq[0]   = v;
        step();
        d_valid[0] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step();
        look();
        chk("rst_in_ready", 32'(a_ir[0]), 32'd0);
        chk("rst_fill", a_fill[0], 32'd0);
        chk("rst_out_valid", 32'(a_ov[0]), 32'd0);
        chk("rst_out_seq", a_seq[0], 32'd0);
        step();
        rst = 1'b0;
        look();
        chk("post_rst_in_ready", 32'(a_ir[0]), 32'd1);

        d_ordy[0] = 1'b1;
        beat(7, 32'b1111111);
        beat(7, 32'b1000011);
        beat(3, 32'b1010110);
        look();
        chk("w1_valid", 32'(a_ov[0]), 32'd1);
        chk("w1_word", a_seq[0], 32'hFF0F);
        chk("w1_fill", a_fill[0], 32'd17);
        step();
        look();
        chk("w1_left", a_fill[0], 32'd1);

        d_ordy[0] = 1'b0;
        beat(7, 32'b0011001);
        beat(7, 32'b1110001);
        beat(1, 32'b1);
        look();
        chk("stall_word", a_seq[0], 32'h19E3);
        d_valid[0] = 1'b1;
        d_num[0]   = 7;
        d_seq[0]   = 32'h55;
        repeat (10) begin
            step();
            look();
            chk("stall_in_ready", 32'(a_ir[0]), 32'd0);
            chk("stall_fill", a_fill[0], 32'd16);
            chk("stall_seq", a_seq[0], 32'h19E3);
        end
        d_valid[0] = 1'b0;
        d_ordy[0]  = 1'b1;
        step();
        look();
        chk("drain_fill", a_fill[0], 32'd0);

        d_ordy[0] = 1'b0;
        beat(7, 32'b1010101);
        beat(7, 32'b0000000);
        beat(6, 32'b111100);
        look();
        chk("f20_fill", a_fill[0], 32'd20);
        chk("f20_word", a_seq[0], 32'hAA03);
        chk("f20_in_ready", 32'(a_ir[0]), 32'd0);
        d_ordy[0] = 1'b1;
        beat(7, 32'b0110011);
        look();
        chk("both_fire_fill", a_fill[0], 32'd11);
        chk("both_fire_valid", 32'(a_ov[0]), 32'd0);
        beat(5, 32'b10101);
        look();
        chk("leftover_word", a_seq[0], 32'hC675);
        chk("leftover_fill", a_fill[0], 32'd16);
        step();

        beat(7, 32'h7F);
        beat(2, 32'b11);
        look();
        chk("pre_rst_fill", a_fill[0], 32'd9);
        rst = 1'b1;
        step();
        look();
        chk("mid_rst_fill", a_fill[0], 32'd0);
        chk("mid_rst_valid", 32'(a_ov[0]), 32'd0);
        chk("mid_rst_in_ready", 32'(a_ir[0]), 32'd0);
        step();
        rst = 1'b0;
        look();
        chk("rst_release_in_ready", 32'(a_ir[0]), 32'd1);
        beat(7, 32'b0110110);
        beat(7, 32'b1001001);
        beat(2, 32'b01);
        look();
        chk("fresh_word", a_seq[0], 32'h6D25);
        chk("fresh_fill", a_fill[0], 32'd16);
        step();

        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                d_valid[k] = ($urandom_range(0, 3) != 0);
                d_num[k]   = $urandom_range(0, iw_of(k));
                d_seq[k]   = $urandom;
                d_ordy[k]  = ($urandom_range(0, 2) != 0);
            end
            rst = (cyc == 4000 || cyc == 7000);
            step();
        end
        rst = 1'b0;
        d_valid[0] = 1'b0;
        d_valid[1] = 1'b0;
        step();

`ifdef SEQ_PACKER_FLUSH_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_en[0] = 1'b0;
        d_ordy[0] = 1'b0;
        beat(5, 32'b10110);
        look();
        chk("flush_pre_fill", a_fill[0], 32'd5);
        flush0 = 1'b1;
        step();
        flush0 = 1'b0;
        look();
        chk("flush_valid", 32'(a_ov[0]), 32'd1);
        chk("flush_last", 32'(ifa.out_last), 32'd1);
        chk("flush_word", a_seq[0], 32'hB000);
        chk("flush_in_ready", 32'(a_ir[0]), 32'd0);
        d_ordy[0] = 1'b1;
        step();
        look();
        chk("flush_done_fill", a_fill[0], 32'd0);
        chk("flush_done_valid", 32'(a_ov[0]), 32'd0);
        chk("flush_done_last", 32'(ifa.out_last), 32'd0);
        chk("flush_done_in_ready", 32'(a_ir[0]), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_en[0] = 1'b1;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
